// File: rtl/led_band_pkg.sv
// Shared types and constants for the LED band sequencer: FSM states, command
// window lengths and the per-phase pulse count lookup.
package led_band_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FCWRTEN = 3'd1,
    FCDATA  = 3'd2,
    WRTFC   = 3'd3,
    GSDATA  = 3'd4
  } state_e;

  localparam int FC_BITS     = 48;
  localparam int GS_BITS     = 48;
  localparam int FCWRTEN_LEN = 15;
  localparam int WRTFC_LEN   = 5;
  localparam int WRTGS_LEN   = 1;
  localparam int LATGS_LEN   = 3;

  // Number of SCLK pulses that make up one phase (one GS word for GSDATA).
  function automatic logic [5:0] phase_pulses(input state_e s);
    case (s)
      FCWRTEN: phase_pulses = 6'(FCWRTEN_LEN);
      FCDATA:  phase_pulses = 6'(FC_BITS);
      WRTFC:   phase_pulses = 6'(WRTFC_LEN);
      GSDATA:  phase_pulses = 6'(GS_BITS);
      default: phase_pulses = 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/led_band_sequencer_sclk.sv
// Gated SCLK divider: while enabled it idles low for SCLK_DIV clk, then toggles
// every SCLK_DIV clk and counts rising edges. Clearing parks it low at zero.
module led_sclk_gen
  import led_band_pkg::*;
#(
  parameter int SCLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       clr_i,
  output logic       sclk_o,
  output logic       rise_pulse_o,
  output logic       fall_pulse_o,
  output logic [5:0] pulse_cnt_o
);

  localparam int HW = $clog2(SCLK_DIV);

  logic [HW-1:0] half_q, half_d;
  logic          sclk_q, sclk_d;
  logic [5:0]    cnt_q, cnt_d;
  logic          wrap;

  assign wrap = (half_q == HW'(SCLK_DIV - 1));

  // Strobes flag that SCLK changes at the coming clk edge.
  assign rise_pulse_o = en_i && !clr_i && wrap && !sclk_q;
  assign fall_pulse_o = en_i && !clr_i && wrap && sclk_q;
  assign sclk_o       = sclk_q;
  assign pulse_cnt_o  = cnt_q;

  always_comb begin
    half_d = half_q;
    sclk_d = sclk_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      half_d = '0;
      sclk_d = 1'b0;
      cnt_d  = '0;
    end else if (en_i) begin
      if (wrap) begin
        half_d = '0;
        sclk_d = !sclk_q;
        if (!sclk_q) cnt_d = cnt_q + 6'd1;
      end else begin
        half_d = half_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_q <= '0;
      sclk_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      half_q <= half_d;
      sclk_q <= sclk_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/led_band_sequencer.sv
// LED band bus master: arbitrates FC-write and GS-frame requests and sequences
// SCLK/LAT so every LAT-high window holds exactly the command's edge count.
module led_band_sequencer
  import led_band_pkg::*;
#(
  parameter int SCLK_DIV = 2,
  parameter int N_WORDS  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fc_req,
  input  logic       gs_req,
  output logic       SCLK,
  output logic       LAT,
  output logic       sel_fc,
  output logic       busy,
  output logic       fc_done,
  output logic       gs_done,
  output logic [3:0] gs_word_idx,
  output logic [5:0] gs_bit_idx,
  output state_e     state_o
);

  localparam int          GW        = $clog2(2 * SCLK_DIV + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(2 * SCLK_DIV);
  localparam logic [5:0]  WRTGS_AT  = 6'(GS_BITS - WRTGS_LEN);
  localparam logic [5:0]  LATGS_AT  = 6'(GS_BITS - LATGS_LEN);

  state_e        state_q, state_d;
  logic          tail_q, tail_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          lat_q, lat_d;
  logic          sel_fc_q, sel_fc_d;
  logic [3:0]    word_q, word_d;
  logic [5:0]    bit_q, bit_d;
  logic          fc_done_q, fc_done_d;
  logic          gs_done_q, gs_done_d;
  logic          fell_q, fell_d;

  logic          run;
  logic          rise_pulse, fall_pulse;
  logic [5:0]    pulse_cnt;
  logic          last_word;
  logic [5:0]    lat_at;
  logic          unused_rise;

  // tail_q covers the clk after the last falling edge through the end of the gap.
  assign run       = (state_q != IDLE) && !tail_q;
  assign last_word = (word_q == 4'(N_WORDS - 1));
  assign lat_at    = last_word ? LATGS_AT : WRTGS_AT;

  led_sclk_gen #(.SCLK_DIV(SCLK_DIV)) u_sclk (
    .clk          (clk),
    .rst          (rst),
    .en_i         (run),
    .clr_i        (!run),
    .sclk_o       (SCLK),
    .rise_pulse_o (rise_pulse),
    .fall_pulse_o (fall_pulse),
    .pulse_cnt_o  (pulse_cnt)
  );

  assign unused_rise = rise_pulse;

  always_comb begin
    state_d   = state_q;
    tail_d    = tail_q;
    gap_d     = gap_q;
    lat_d     = lat_q;
    sel_fc_d  = sel_fc_q;
    word_d    = word_q;
    bit_d     = bit_q;
    fc_done_d = 1'b0;
    gs_done_d = 1'b0;
    fell_d    = fall_pulse;
    if (state_q == IDLE) begin
      if (fc_req) begin
        state_d  = FCWRTEN;
        lat_d    = 1'b1;
        sel_fc_d = 1'b1;
      end else if (gs_req) begin
        state_d  = GSDATA;
        lat_d    = 1'b0;
        sel_fc_d = 1'b0;
        word_d   = 4'd0;
        bit_d    = 6'd47;
      end
    end else if (!tail_q) begin
      if (state_q == GSDATA && fall_pulse && bit_q != 6'd0) bit_d = bit_q - 6'd1;
      // fell_q marks the clk right after a falling edge: LAT may move there.
      if (state_q == GSDATA && fell_q && pulse_cnt == lat_at) lat_d = 1'b1;
      if (fall_pulse && pulse_cnt == phase_pulses(state_q)) begin
        tail_d = 1'b1;
        gap_d  = '0;
      end
    end else begin
      lat_d = 1'b0;
      if (gap_q == GAP_LAST) begin
        tail_d = 1'b0;
        gap_d  = '0;
        bit_d  = 6'd47;
        case (state_q)
          FCWRTEN: state_d = FCDATA;
          FCDATA: begin
            state_d = WRTFC;
            lat_d   = 1'b1;
          end
          WRTFC: begin
            state_d   = IDLE;
            fc_done_d = 1'b1;
          end
          GSDATA: begin
            if (last_word) begin
              state_d   = IDLE;
              gs_done_d = 1'b1;
              word_d    = 4'd0;
            end else begin
              word_d = word_q + 4'd1;
            end
          end
          default: state_d = IDLE;
        endcase
      end else begin
        gap_d = gap_q + GW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tail_q    <= 1'b0;
      gap_q     <= '0;
      lat_q     <= 1'b0;
      sel_fc_q  <= 1'b1;
      word_q    <= 4'd0;
      bit_q     <= 6'd47;
      fc_done_q <= 1'b0;
      gs_done_q <= 1'b0;
      fell_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tail_q    <= tail_d;
      gap_q     <= gap_d;
      lat_q     <= lat_d;
      sel_fc_q  <= sel_fc_d;
      word_q    <= word_d;
      bit_q     <= bit_d;
      fc_done_q <= fc_done_d;
      gs_done_q <= gs_done_d;
      fell_q    <= fell_d;
    end
  end

  assign LAT         = lat_q;
  assign sel_fc      = sel_fc_q;
  assign busy        = (state_q != IDLE);
  assign fc_done     = fc_done_q;
  assign gs_done     = gs_done_q;
  assign gs_word_idx = word_q;
  assign gs_bit_idx  = bit_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_led_band_sequencer.sv
// Bench for led_band_sequencer: directed FC/GS operations, expected bus events
// queued per operation and compared by an independent negedge monitor.
module tb_led_band_sequencer;
  import led_band_pkg::*;

  localparam int DIV = 2;
  localparam int NW  = 2;
  localparam int W   = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       fc_req;
  logic       gs_req;
  logic       SCLK;
  logic       LAT;
  logic       sel_fc;
  logic       busy;
  logic       fc_done;
  logic       gs_done;
  logic [3:0] gs_word_idx;
  logic [5:0] gs_bit_idx;
  state_e     state_o;

  int checks = 0;
  int errors = 0;

  // Event = {kind(0 edge,1 fc_done,2 gs_done), busy, LAT, sel_fc, word, bit}
  logic [W-1:0] exp_q[$];

  led_band_sequencer #(.SCLK_DIV(DIV), .N_WORDS(NW)) dut (
    .clk         (clk),
    .rst         (rst),
    .fc_req      (fc_req),
    .gs_req      (gs_req),
    .SCLK        (SCLK),
    .LAT         (LAT),
    .sel_fc      (sel_fc),
    .busy        (busy),
    .fc_done     (fc_done),
    .gs_done     (gs_done),
    .gs_word_idx (gs_word_idx),
    .gs_bit_idx  (gs_bit_idx),
    .state_o     (state_o)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_compare(input logic [W-1:0] got);
    logic [W-1:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: got event %h with empty queue", got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL sb_event: got %h expected %h (%0d left)", got, exp, exp_q.size());
      end
    end
  endtask

  // Expected-event builders
  task automatic push_fc_edges(input int n);
    logic lat;
    for (int k = 1; k <= n; k++) begin
      lat = (k <= 15) || (k > 63);
      exp_q.push_back({2'd0, 1'b1, lat, 1'b1, 4'd0, 6'd47});
    end
  endtask

  task automatic push_fc_done();
    exp_q.push_back({2'd1, 1'b0, 1'b0, 1'b1, 4'd0, 6'd47});
  endtask

  task automatic push_gs();
    logic lat;
    for (int w = 0; w < NW; w++) begin
      for (int k = 1; k <= 48; k++) begin
        lat = (w == NW - 1) ? (k >= 46) : (k == 48);
        exp_q.push_back({2'd0, 1'b1, lat, 1'b0, 4'(w), 6'(48 - k)});
      end
    end
    exp_q.push_back({2'd2, 1'b0, 1'b0, 1'b0, 4'd0, 6'd47});
  endtask

  // Driver tasks
  task automatic pulse_fc();
    @(negedge clk); #2 fc_req = 1'b1;
    @(negedge clk); #2 fc_req = 1'b0;
  endtask

  task automatic wait_empty(input int budget, input string name);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #3;
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d events outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor
  initial begin
    logic prev_sclk;
    logic prev_lat;
    int   hi_cnt;
    prev_sclk = 1'b0;
    prev_lat  = 1'b0;
    hi_cnt    = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_sclk = SCLK;
        prev_lat  = LAT;
        hi_cnt    = 0;
      end else begin
        if (LAT !== prev_lat) chk("lat_move_sclk_quiet", 32'({SCLK, prev_sclk}), 32'd0);
        if (SCLK && !prev_sclk) begin
          hi_cnt = 1;
          sb_compare({2'd0, busy, LAT, sel_fc, gs_word_idx, gs_bit_idx});
        end else if (SCLK) begin
          hi_cnt++;
        end
        if (!SCLK && prev_sclk) chk("sclk_high_width", 32'(hi_cnt), 32'(DIV));
        if (fc_done) sb_compare({2'd1, busy, LAT, sel_fc, gs_word_idx, gs_bit_idx});
        if (gs_done) sb_compare({2'd2, busy, LAT, sel_fc, gs_word_idx, gs_bit_idx});
        prev_sclk = SCLK;
        prev_lat  = LAT;
      end
    end
  end

  // Stimulus
  initial begin
    bit started;
    rst    = 1'b1;
    fc_req = 1'b0;
    gs_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sclk", 32'(SCLK), 32'd0);
    chk("rst_lat", 32'(LAT), 32'd0);
    chk("rst_sel_fc", 32'(sel_fc), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fc_done", 32'(fc_done), 32'd0);
    chk("rst_gs_done", 32'(gs_done), 32'd0);
    chk("rst_word", 32'(gs_word_idx), 32'd0);
    chk("rst_bit", 32'(gs_bit_idx), 32'd47);
    chk("rst_state", 32'(state_o), 32'(IDLE));
    #2 rst = 1'b0;

    // 1: FC write
    push_fc_edges(68);
    push_fc_done();
    pulse_fc();
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_sel_fc", 32'(sel_fc), 32'd1);
    wait_empty(2000, "t1");
    chk("t1_busy_after", 32'(busy), 32'd0);

    // 2: GS frame of NW words
    push_gs();
    @(negedge clk); #2 gs_req = 1'b1;
    @(negedge clk); #2 gs_req = 1'b0;
    chk("t2_busy", 32'(busy), 32'd1);
    chk("t2_sel_fc", 32'(sel_fc), 32'd0);
    chk("t2_word", 32'(gs_word_idx), 32'd0);
    chk("t2_bit", 32'(gs_bit_idx), 32'd47);
    wait_empty(2000, "t2");

    // 3: simultaneous requests, gs_req held until the frame starts
    push_fc_edges(68);
    push_fc_done();
    push_gs();
    @(negedge clk); #2 fc_req = 1'b1; gs_req = 1'b1;
    @(negedge clk); #2 fc_req = 1'b0;
    chk("t3_fc_first", 32'(sel_fc), 32'd1);
    started = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!sel_fc) begin
        started = 1'b1;
        break;
      end
    end
    chk("t3_gs_follows", 32'(started), 32'd1);
    #2 gs_req = 1'b0;
    wait_empty(2000, "t3");

    // 4: gs_req during an FC write is dropped
    push_fc_edges(68);
    push_fc_done();
    pulse_fc();
    repeat (100) @(negedge clk);
    #2 gs_req = 1'b1;
    @(negedge clk); #2 gs_req = 1'b0;
    wait_empty(2000, "t4");
    repeat (30) @(negedge clk);
    chk("t4_no_gs", 32'(busy), 32'd0);

    // 5: reset at FCDATA pulse 20, then a clean restart
    push_fc_edges(35);
    pulse_fc();
    wait_empty(2000, "t5_partial");
    chk("t5_mid_pulse", 32'(SCLK), 32'd1);
    rst = 1'b1;
    #1;
    chk("t5_rst_sclk", 32'(SCLK), 32'd0);
    chk("t5_rst_lat", 32'(LAT), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_sel_fc", 32'(sel_fc), 32'd1);
    chk("t5_rst_state", 32'(state_o), 32'(IDLE));
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    push_fc_edges(68);
    push_fc_done();
    pulse_fc();
    wait_empty(2000, "t5_restart");

    repeat (20) @(negedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_band_sequencer.md
Name: led_band_sequencer

Overview:
- Sole master of the LED-driver serial bus for one LED band.
- Generates SCLK and LAT from the system clock.
- Sequences two operations:
  - function-control (FC) write: FCWRTEN, then 48 data bits, then WRTFC.
  - grayscale (GS) frame: N_WORDS words of 48 bits, each closed by WRTGS; the final word is closed by LATGS instead.
- Arbitrates between the FC-write request and the GS-frame request, and tells the SOUT mux which source (FC setter or GS buffer) drives the bus.

Parameters:
- SCLK_DIV, 2, clk cycles per SCLK half-period. Legal values are 2 and above; 1 is forbidden.
- N_WORDS, 16, 48-bit GS words per frame. Legal values are 1 to 16.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- fc_req, input, 1, request an FC write. Sampled only in IDLE.
- gs_req, input, 1, request a GS frame. Sampled only in IDLE.
- SCLK, output, 1, driver shift clock.
- LAT, output, 1, driver latch/command line.
- sel_fc, output, 1, 1 = SOUT taken from the FC setter; 0 = SOUT taken from the GS data source.
- busy, output, 1, high from the accept cycle until the cycle before done.
- fc_done, output, 1, one-clk pulse at the end of an FC write.
- gs_done, output, 1, one-clk pulse at the end of a GS frame.
- gs_word_idx, output, 4, index of the GS word being shifted.
- gs_bit_idx, output, 6, index of the bit to present on the next SCLK rising edge (MSB first, 47 down to 0).

Behaviour:
Reset values:
- SCLK=0, LAT=0, sel_fc=1, busy=0, fc_done=0, gs_done=0, gs_word_idx=0, gs_bit_idx=47, state=IDLE.
- Reset mid-operation forces these values immediately; no partial sequence resumes.

SCLK pulse definition:
- A "pulse" is SCLK high for SCLK_DIV clk, then low for SCLK_DIV clk.
- SCLK is held low outside pulses.
- SCLK only toggles in FCWRTEN, FCDATA, WRTFC and GSDATA.

LAT timing rules:
- LAT changes only while SCLK is low, never on the clk of an SCLK edge.
- When a phase raises LAT at its start, LAT rises on the phase-entry clk and the first pulse begins SCLK_DIV clk later.
- LAT falls 1 clk after the falling edge of the last pulse of its window.
- Between phases: one gap of 2*SCLK_DIV clk with SCLK low and LAT low.

Arbitration (IDLE only):
- fc_req has priority over gs_req when both are high in the same cycle.
- Acceptance takes one cycle; busy rises the next clk.
- Requests raised while busy are ignored, not queued.

State transitions:
- IDLE: on fc_req go to FCWRTEN with sel_fc=1; otherwise on gs_req go to GSDATA with sel_fc=0 and gs_word_idx=0.
- FCWRTEN: LAT high for exactly 15 pulses, then gap, then FCDATA.
- FCDATA: LAT low, exactly 48 pulses, then gap, then WRTFC.
- WRTFC: LAT high for exactly 5 pulses, then gap, then IDLE with a fc_done pulse.
- GSDATA (each word):
  - 48 pulses; gs_bit_idx=47 at word start and decrements on the clk of each SCLK falling edge.
  - Not the last word: LAT rises 1 clk after the falling edge of pulse 47, covering pulse 48 only (WRTGS).
  - Last word (gs_word_idx = N_WORDS-1): LAT rises 1 clk after the falling edge of pulse 45, covering pulses 46 to 48 (LATGS).
  - After LAT falls: gap, then gs_word_idx increments and gs_bit_idx reloads to 47.
  - After the last word: IDLE with a gs_done pulse.

Index wrap rules:
- gs_bit_idx never wraps below 0: it stays at 0 after pulse 48 and is reloaded to 47 at the next word start.
- gs_word_idx returns to 0 on entry to IDLE.

Command window rule:
- Every LAT-high window contains exactly the stated number of SCLK rising edges; the driver decodes commands by this count.

Decomposition:
- Shared package led_band_pkg holds:
  - state enum: IDLE, FCWRTEN, FCDATA, WRTFC, GSDATA.
  - constants: FC_BITS=48, GS_BITS=48, FCWRTEN_LEN=15, WRTFC_LEN=5, WRTGS_LEN=1, LATGS_LEN=3.
- Sub-module led_sclk_gen:
  - gated SCLK divider.
  - outputs sclk, rise_pulse, fall_pulse, and a pulse counter cleared by the FSM.

Test Plan:
1. SCLK_DIV=2; fc_req pulse in IDLE -> sel_fc=1; 15 rising edges with LAT high; 48 with LAT low; 5 with LAT high; 68 edges total; one fc_done pulse; busy low after it.
2. N_WORDS=2; gs_req -> word 0: 48 edges, LAT high over edge 48 only; word 1: LAT high over edges 46-48; gs_bit_idx walks 47 to 0 per word; one gs_done pulse; sel_fc=0 throughout.
3. fc_req and gs_req high in the same IDLE cycle -> FC write runs first; gs_req held high -> GS frame starts only after fc_done.
4. gs_req pulsed during an FC write -> ignored; exactly one operation executed.
5. Assert rst at FCDATA pulse 20 -> SCLK=0, LAT=0, busy=0, sel_fc=1 in the same cycle; a new fc_req restarts from FCWRTEN with the full 15 edges.
6. Check on every LAT transition that SCLK is low and that no SCLK edge occurs in the same clk.
